// File: rtl/cacheline_mem_arbiter.sv
// Cacheline-to-burst arbiter between I-cache, D-cache and a 64-bit memory port.
// Define ARB_DCACHE_PRIORITY_EN for fixed D-cache priority; default is round-robin.
module cacheline_mem_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           ic_addr,
  input  logic                  ic_read,
  output logic [LINE_WIDTH-1:0] ic_rdata,
  output logic                  ic_resp,
  input  logic [31:0]           dc_addr,
  input  logic                  dc_read,
  input  logic                  dc_write,
  input  logic [LINE_WIDTH-1:0] dc_wdata,
  output logic [LINE_WIDTH-1:0] dc_rdata,
  output logic                  dc_resp,
  output logic [31:0]           mem_addr,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [BEAT_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_raddr,
  input  logic [BEAT_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid
);

  localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ_REQ,
    READ_WAIT,
    RESP
  } state_t;

  state_t                state;
  logic [BW-1:0]         beat;
  logic [LINE_WIDTH-1:0] wb_line;
  logic [LINE_WIDTH-1:0] rd_line;
  logic [LINE_WIDTH-1:0] line_next;
  logic                  win_dc;
  logic                  is_write;
`ifndef ARB_DCACHE_PRIORITY_EN
  logic                  last_ic;
`endif

  logic        dc_req;
  logic        ic_req;
  logic        grant_dc;
  logic [31:0] sel_addr;
  logic        tag_hit;
  logic        last_beat;
  logic        unused_bits;

  assign dc_req    = dc_read | dc_write;
  assign ic_req    = ic_read;
  assign sel_addr  = grant_dc ? dc_addr : ic_addr;
  assign tag_hit   = mem_raddr[31:5] == mem_addr[31:5];
  assign last_beat = beat == LAST;
  assign unused_bits = ^{ic_addr[4:0], dc_addr[4:0], mem_raddr[4:0]};

  // Beat data comes from the latched line, indexed by the registered beat.
  assign mem_wdata = mem_write
    ? wb_line[int'(beat)*BEAT_WIDTH +: BEAT_WIDTH]
    : '0;

  // Winner selection while idle; the pointer remembers who was granted last.
  always_comb begin
`ifdef ARB_DCACHE_PRIORITY_EN
    grant_dc = dc_req;
`else
    grant_dc = dc_req && (!ic_req || last_ic);
`endif
  end

  // Line being assembled with the current read beat merged in.
  always_comb begin
    line_next = rd_line;
    line_next[int'(beat)*BEAT_WIDTH +: BEAT_WIDTH] = mem_rdata;
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      beat      <= '0;
      wb_line   <= '0;
      rd_line   <= '0;
      win_dc    <= 1'b0;
      is_write  <= 1'b0;
`ifndef ARB_DCACHE_PRIORITY_EN
      last_ic   <= 1'b1;
`endif
      mem_addr  <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      ic_resp   <= 1'b0;
      dc_resp   <= 1'b0;
      ic_rdata  <= '0;
      dc_rdata  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (dc_req || ic_req) begin
            mem_addr <= {sel_addr[31:5], 5'b0};
            wb_line  <= dc_wdata;
            win_dc   <= grant_dc;
            is_write <= grant_dc && dc_write;
            beat     <= '0;
`ifndef ARB_DCACHE_PRIORITY_EN
            last_ic  <= !grant_dc;
`endif
            if (grant_dc && dc_write) begin
              mem_write <= 1'b1;
              state     <= WRITE;
            end else begin
              mem_read <= 1'b1;
              state    <= READ_REQ;
            end
          end
        end
        WRITE: begin
          if (mem_ready) begin
            if (last_beat) begin
              mem_write <= 1'b0;
              beat      <= '0;
              ic_resp   <= !win_dc;
              dc_resp   <= win_dc;
              state     <= RESP;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        READ_REQ: begin
          if (mem_ready) begin
            mem_read <= 1'b0;
            state    <= READ_WAIT;
          end
        end
        READ_WAIT: begin
          if (mem_rvalid && tag_hit) begin
            rd_line <= line_next;
            if (last_beat) begin
              beat    <= '0;
              ic_resp <= !win_dc;
              dc_resp <= win_dc;
              if (win_dc) dc_rdata <= line_next;
              else        ic_rdata <= line_next;
              state   <= RESP;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        RESP: begin
          ic_resp <= 1'b0;
          dc_resp <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cacheline_mem_arbiter.md
# cacheline_mem_arbiter

Shares the single 64-bit burst memory port between the instruction cache and the pipelined data cache. Accepts whole-cacheline (256-bit) read/write requests from both caches, serializes each into 4-beat bursts, reassembles read beats into a line and returns a one-cycle response to the granted cache. Sits between the cache DFP ports and the memory model/controller; one transaction is outstanding at a time.

## Interface
- LINE_WIDTH, 256, cacheline width in bits.
- BEAT_WIDTH, 64, memory beat width; BEATS = LINE_WIDTH/BEAT_WIDTH = 4.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset (rst == 0 resets).
- ic_addr  in  32  I-cache line address (bits [4:0] ignored).
- ic_read  in  1  I-cache line read request, level, held until ic_resp.
- ic_rdata  out  256  line returned to I-cache.
- ic_resp  out  1  one-cycle completion pulse to I-cache.
- dc_addr  in  32  D-cache line address.
- dc_read / dc_write  in  1 each  D-cache request, level, mutually exclusive, held until dc_resp.
- dc_wdata  in  256  writeback line.
- dc_rdata  out  256  line returned to D-cache.
- dc_resp  out  1  one-cycle completion pulse to D-cache.
- mem_addr  out  32  burst address, low 5 bits zero.
- mem_read  out  1  one-cycle read command.
- mem_write  out  1  write beat valid.
- mem_wdata  out  64  write beat data.
- mem_ready  in  1  memory accepts command/beat this cycle.
- mem_raddr  in  32  address tag of returning read data.
- mem_rdata  in  64  read beat data.
- mem_rvalid  in  1  read beat valid.

## Operation
- States: IDLE, WRITE, READ_REQ, READ_WAIT, RESP.
- IDLE: if any request, pick winner (see Configuration), latch {addr[31:5],5'b0}, op, wdata, winner id; dc_write -> WRITE, any read -> READ_REQ. No request -> stay.
- WRITE: mem_write=1, mem_addr=latched, mem_wdata=wdata[64*beat+:64], beat from 0. Beat advances only when mem_ready=1; after beat 3 accepted -> RESP.
- READ_REQ: mem_read=1, mem_addr=latched; when mem_ready=1 -> READ_WAIT (mem_read high exactly one accepted cycle).
- READ_WAIT: on mem_rvalid && mem_raddr[31:5]==latched[31:5], store mem_rdata into line[64*beat+:64], beat++; after beat 3 -> RESP. Mismatched or out-of-state rvalid beats are dropped.
- RESP: assert winner's resp for exactly one cycle; winner's rdata holds assembled line (writes: rdata unspecified, hold previous). -> IDLE. Non-winner resp stays 0.
- Requests are not re-sampled during a transaction; a request that drops mid-transaction is still completed and responded to.
- ic_rdata/dc_rdata hold last assembled line until next read completion for that port.

## Timing
- Reset (rst=0 on a clock edge): state IDLE, beat 0, all mem_* outputs 0, ic_resp=dc_resp=0, ic_rdata=dc_rdata=0, round-robin pointer = I-cache (first tie goes to D-cache). Reset mid-transaction abandons it without resp.
- Grant decision is combinational in IDLE, registered into state; first mem command appears the cycle after request is seen.
- Read, memory always ready, data 1 cycle after command back-to-back: request@T0, mem_read@T1, beats T2..T5, resp@T6 (6 cycles).
- Write, always ready: request@T0, beats T1..T4, resp@T5.
- Resp cycle precedes IDLE; earliest next grant is cycle after resp, so a cache's next-state request (e.g. D-cache writeback -> allocate) is sampled fresh.
- Every output is registered-state-driven; no input-to-output combinational path except none (mem_wdata selected by registered beat).

## Configuration
- ARB_DCACHE_PRIORITY_EN defined: fixed priority, D-cache wins whenever dc_read|dc_write in IDLE; I-cache only when D-cache idle.
- Undefined (default): round-robin; on simultaneous requests grant the port not granted last; pointer updates on every grant.

## Test plan
- Single I-cache read of 0x0000_1234, memory ready, beats 0x11..,0x22..,0x33..,0x44.. -> mem_addr=0x0000_1220, ic_resp one cycle at T6, ic_rdata={0x44..,0x33..,0x22..,0x11..}, dc_resp=0.
- D-cache write 0x8000_0040 with mem_ready low on beat 2 for 3 cycles -> beat 2 data held stable, exactly 4 accepted beats in order, dc_resp at completion.
- Simultaneous ic_read and dc_read from reset, repeated 4 times -> round-robin grants D,I,D,I; with ARB_DCACHE_PRIORITY_EN all D until dc idle.
- Stale rvalid with mem_raddr 0x0000_2000 during read of 0x0000_1000 -> beat ignored, line assembled only from matching beats.
- Assert rst=0 during READ_WAIT beat 2 -> next cycle IDLE, all outputs 0, no resp; subsequent read completes normally.
- D-cache writeback then immediate allocate read -> two separate transactions, two dc_resp pulses, I-cache request pending meanwhile gets granted per policy.
